// File: rtl/light_phase_monitor.sv
// light_phase_monitor: watches the traffic-light pass line, locks onto the
// go/stop cadence, and counts completed periods and run-length violations.
//
// Ports:
//   clk      in   1         clock, all state updates on posedge
//   rst      in   1         asynchronous, active-high reset
//   pass     in   1         light output under observation
//   locked   out  1         a full valid period seen since last sync
//   error    out  1         one-cycle pulse on a run-length violation
//   run_len  out  CNT_W     length of current run incl. this sample (0 in SEEK)
//   periods  out  PERIOD_W  completed valid periods since reset (wraps)
//   err_cnt  out  8         violations since reset (saturates at 255)
module light_phase_monitor #(
    parameter int PASS_CYCLES = 7,
    parameter int STOP_CYCLES = 7,
    parameter int CNT_W       = 4,
    parameter int PERIOD_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pass,
    output logic                locked,
    output logic                error,
    output logic [CNT_W-1:0]    run_len,
    output logic [PERIOD_W-1:0] periods,
    output logic [7:0]          err_cnt
);

    typedef enum logic [1:0] {
        SEEK = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0]    PASS_LEN = CNT_W'(PASS_CYCLES);
    localparam logic [CNT_W-1:0]    STOP_LEN = CNT_W'(STOP_CYCLES);
    localparam logic [CNT_W-1:0]    ONE      = CNT_W'(1);
    localparam logic [PERIOD_W-1:0] P_ONE    = PERIOD_W'(1);

    state_t                r_state;
    logic                  r_pass_q;
    logic                  r_locked;
    logic                  r_error;
    logic [CNT_W-1:0]      r_run_len;
    logic [PERIOD_W-1:0]   r_periods;
    logic [7:0]            r_err_cnt;

    logic                  w_rise;
    logic [CNT_W-1:0]      w_next_len;
    logic                  w_viol;

    always_comb begin
        w_rise     = ~r_pass_q & pass;
        w_next_len = r_run_len + ONE;
        w_viol     = 1'b0;
        unique case (r_state)
            HIGH: begin
                if (pass) w_viol = (w_next_len > PASS_LEN);
                else      w_viol = (r_run_len != PASS_LEN);
            end
            LOW: begin
                if (!pass) w_viol = (w_next_len > STOP_LEN);
                else       w_viol = (r_run_len != STOP_LEN);
            end
            default: w_viol = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= SEEK;
            // Starting high means a real 0->1 edge is needed before tracking.
            r_pass_q  <= 1'b1;
            r_locked  <= 1'b0;
            r_error   <= 1'b0;
            r_run_len <= '0;
            r_periods <= '0;
            r_err_cnt <= '0;
        end else begin
            r_pass_q <= pass;
            r_error  <= w_viol;
            if (w_viol) begin
                // The violating sample is spent in SEEK; a coincident rise is dropped.
                r_state   <= SEEK;
                r_locked  <= 1'b0;
                r_run_len <= '0;
                if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
            end else begin
                unique case (r_state)
                    SEEK: begin
                        if (w_rise) begin
                            r_state   <= HIGH;
                            r_run_len <= ONE;
                        end
                    end
                    HIGH: begin
                        if (pass) begin
                            r_run_len <= w_next_len;
                        end else begin
                            r_state   <= LOW;
                            r_run_len <= ONE;
                        end
                    end
                    LOW: begin
                        if (!pass) begin
                            r_run_len <= w_next_len;
                        end else begin
                            r_state   <= HIGH;
                            r_run_len <= ONE;
                            r_periods <= r_periods + P_ONE;
                            r_locked  <= 1'b1;
                        end
                    end
                    default: begin
                        r_state   <= SEEK;
                        r_run_len <= '0;
                    end
                endcase
            end
        end
    end

    assign locked  = r_locked;
    assign error   = r_error;
    assign run_len = r_run_len;
    assign periods = r_periods;
    assign err_cnt = r_err_cnt;

endmodule

// File: tb/tb_light_phase_monitor.sv
// Directed bench for light_phase_monitor: lock, violations, reset, wrap
// and saturation, with a second instance at PERIOD_W=2.
module tb_light_phase_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pass = 1'b0;
    logic        locked, error;
    logic [3:0]  run_len;
    logic [15:0] periods;
    logic [7:0]  err_cnt;
    logic        locked2, error2;
    logic [3:0]  run_len2;
    logic [1:0]  periods2;
    logic [7:0]  err_cnt2;

    int checks = 0;
    int failures = 0;
    bit err_seen = 1'b0;

    always #5 clk = ~clk;

    light_phase_monitor dut (
        .clk(clk), .rst(rst), .pass(pass),
        .locked(locked), .error(error), .run_len(run_len),
        .periods(periods), .err_cnt(err_cnt)
    );

    light_phase_monitor #(.PERIOD_W(2)) dut2 (
        .clk(clk), .rst(rst), .pass(pass),
        .locked(locked2), .error(error2), .run_len(run_len2),
        .periods(periods2), .err_cnt(err_cnt2)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic p);
        @(negedge clk);
        pass = p;
        @(posedge clk);
        #1;
        if (error) err_seen = 1'b1;
    endtask

    task automatic run(input logic p, input int n);
        for (int i = 0; i < n; i++) step(p);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        // Reset state
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_locked", 32'(locked), 0);
        chk("rst_error", 32'(error), 0);
        chk("rst_runlen", 32'(run_len), 0);
        chk("rst_periods", 32'(periods), 0);
        chk("rst_errcnt", 32'(err_cnt), 0);
        @(negedge clk);
        rst = 1'b0;

        // 1: first lock
        err_seen = 1'b0;
        run(1'b0, 3);
        chk("s1_seek_runlen", 32'(run_len), 0);
        run(1'b1, 7);
        chk("s1_high7", 32'(run_len), 7);
        chk("s1_nolock", 32'(locked), 0);
        run(1'b0, 7);
        chk("s1_low7", 32'(run_len), 7);
        step(1'b1);
        chk("s1_locked", 32'(locked), 1);
        chk("s1_periods", 32'(periods), 1);
        chk("s1_runlen", 32'(run_len), 1);
        chk("s1_noerr", 32'(err_seen), 0);

        // 2: short high run (6 samples incl. lock sample)
        run(1'b1, 5);
        chk("s2_high6", 32'(run_len), 6);
        step(1'b0);
        chk("s2_error", 32'(error), 1);
        chk("s2_errcnt", 32'(err_cnt), 1);
        chk("s2_unlock", 32'(locked), 0);
        chk("s2_runlen", 32'(run_len), 0);
        step(1'b0);
        chk("s2_err_clr", 32'(error), 0);
        run(1'b1, 7);
        run(1'b0, 7);
        step(1'b1);
        chk("s2_relock", 32'(locked), 1);
        chk("s2_periods", 32'(periods), 2);

        // 3: overlong low run flags on 8th low sample
        run(1'b1, 6);
        run(1'b0, 7);
        chk("s3_low7_ok", 32'(error), 0);
        step(1'b0);
        chk("s3_error", 32'(error), 1);
        chk("s3_runlen", 32'(run_len), 0);
        chk("s3_errcnt", 32'(err_cnt), 2);
        err_seen = 1'b0;
        run(1'b0, 3);
        chk("s3_no_extra", 32'(err_seen), 0);
        chk("s3_errcnt_hold", 32'(err_cnt), 2);
        chk("s3_seek", 32'(locked), 0);

        // 4: pass held high out of reset never produces a rise
        @(negedge clk);
        pass = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        err_seen = 1'b0;
        run(1'b1, 20);
        chk("s4_runlen", 32'(run_len), 0);
        chk("s4_locked", 32'(locked), 0);
        chk("s4_error", 32'(err_seen), 0);
        chk("s4_errcnt", 32'(err_cnt), 0);

        // 5: reach periods=3, reset mid-LOW between edges
        step(1'b0);
        run(1'b1, 7);
        run(1'b0, 7);
        step(1'b1);
        for (int k = 0; k < 2; k++) begin
            run(1'b1, 6);
            run(1'b0, 7);
            step(1'b1);
        end
        chk("s5_periods3", 32'(periods), 3);
        chk("s5_locked", 32'(locked), 1);
        run(1'b1, 6);
        run(1'b0, 3);
        chk("s5_midlow", 32'(run_len), 3);
        #2;
        rst = 1'b1;
        #1;
        chk("s5_async_locked", 32'(locked), 0);
        chk("s5_async_runlen", 32'(run_len), 0);
        chk("s5_async_periods", 32'(periods), 0);
        chk("s5_async_error", 32'(error), 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        run(1'b0, 3);
        run(1'b1, 7);
        run(1'b0, 7);
        step(1'b1);
        chk("s5_relock", 32'(locked), 1);
        chk("s5_periods1", 32'(periods), 1);

        // 6: PERIOD_W=2 wrap, then err_cnt saturation
        do_reset();
        run(1'b0, 2);
        run(1'b1, 7);
        run(1'b0, 7);
        step(1'b1);
        chk("s6_p2_1", 32'(periods2), 1);
        for (int k = 2; k <= 5; k++) begin
            run(1'b1, 6);
            run(1'b0, 7);
            step(1'b1);
            chk("s6_p2_seq", 32'(periods2), 32'(k % 4));
            chk("s6_p16_seq", 32'(periods), 32'(k));
        end
        step(1'b0);
        chk("s6_first_viol", 32'(err_cnt2), 1);
        for (int k = 0; k < 253; k++) begin
            step(1'b1);
            step(1'b0);
        end
        chk("s6_errcnt254", 32'(err_cnt2), 254);
        for (int k = 0; k < 46; k++) begin
            step(1'b1);
            step(1'b0);
        end
        chk("s6_sat2", 32'(err_cnt2), 255);
        chk("s6_sat1", 32'(err_cnt), 255);
        chk("s6_periods_kept", 32'(periods), 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
